// File: rtl/game_pkg.sv
// Shared game-controller definitions: button indices, button count and the
// auto-repeat FSM state type used by button_conditioner.
package game_pkg;

    // Button bit positions on the pad bus
    localparam int unsigned BTN_MOVE_L  = 0;
    localparam int unsigned BTN_MOVE_R  = 1;
    localparam int unsigned BTN_AIM_L   = 2;
    localparam int unsigned BTN_AIM_R   = 3;
    localparam int unsigned BTN_SHOOT   = 4;
    localparam int unsigned BTN_START   = 5;

    localparam int unsigned BTN_COUNT        = 6;
    // Buttons 0..BTN_REPEAT_COUNT-1 may auto-repeat; the rest pulse once per press
    localparam int unsigned BTN_REPEAT_COUNT = 4;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    // Bits needed to hold a count of 0 .. max_val-1 (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Pad-button bus: raw inputs toward the conditioner, debounced levels and
// press/repeat strobes back toward the controls stage.
interface button_conditioner_if;
    import game_pkg::*;

    logic [BTN_COUNT-1:0] btn_raw;
    logic [BTN_COUNT-1:0] btn_level;
    logic [BTN_COUNT-1:0] btn_pulse;

    // master: drives raw buttons, consumes conditioned outputs
    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_pulse
    );

    // slave: the conditioner itself
    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_pulse
    );

endinterface

// File: rtl/btn_debounce.sv
// Single-bit button debouncer: 2-flop synchronizer followed by a
// persistence counter. The level toggles once the synchronized input has
// differed from it for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic level_nxt
);

    localparam int unsigned          CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    // Shift the raw pad value through the synchronizer pair
    always_comb begin
        sync_d = {sync_q[0], btn_raw};
    end

    // Count mismatching cycles; toggle the level when the run completes.
    // The counter is bounded by CNT_LAST so it cannot wrap.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level     = level_q;
    assign level_nxt = level_d;

endmodule

// File: rtl/button_conditioner.sv
// Six-button pad conditioner: per-bit debounce plus one-cycle press strobes.
// Define BUTTON_AUTO_REPEAT_EN to enable auto-repeat on the move/aim buttons
// (bits 0-3); without it every button pulses exactly once per press and the
// repeat parameters are unused.
module button_conditioner
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned REPEAT_DELAY    = 4000000,
    parameter int unsigned REPEAT_RATE     = 1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  btn_if
);

    logic [BTN_COUNT-1:0] level;
    logic [BTN_COUNT-1:0] level_nxt;
    logic [BTN_COUNT-1:0] rise;
    logic [BTN_COUNT-1:0] pulse_q, pulse_d;

    for (genvar i = 0; i < BTN_COUNT; i++) begin : g_debounce
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk       (clk),
            .reset     (reset),
            .btn_raw   (btn_if.btn_raw[i]),
            .level     (level[i]),
            .level_nxt (level_nxt[i])
        );
    end

    // Pulse decisions are made one cycle early from the next level, so the
    // registered strobe lines up with the first cycle the level is high.
    assign rise = level_nxt & ~level;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int unsigned      TMR_W      = cnt_width(max_u(REPEAT_DELAY, REPEAT_RATE));
    localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE - 1);

    rpt_state_t                  state_q [BTN_REPEAT_COUNT];
    rpt_state_t                  state_d [BTN_REPEAT_COUNT];
    logic [TMR_W-1:0]            timer_q [BTN_REPEAT_COUNT];
    logic [TMR_W-1:0]            timer_d [BTN_REPEAT_COUNT];
    logic [BTN_REPEAT_COUNT-1:0] rpt_fire;

    // Auto-repeat FSMs: a falling level returns to IDLE with no pulse and
    // a cleared timer, overriding any repeat due in that cycle.
    always_comb begin
        for (int unsigned i = 0; i < BTN_REPEAT_COUNT; i++) begin
            state_d[i]  = state_q[i];
            timer_d[i]  = '0;
            rpt_fire[i] = 1'b0;
            if (!level_nxt[i]) begin
                state_d[i] = RPT_IDLE;
            end else begin
                case (state_q[i])
                    RPT_IDLE: begin
                        if (rise[i]) begin
                            state_d[i] = RPT_DELAY;
                        end
                    end
                    RPT_DELAY: begin
                        if (timer_q[i] == DELAY_LAST) begin
                            state_d[i]  = RPT_REPEAT;
                            rpt_fire[i] = 1'b1;
                        end else begin
                            timer_d[i] = timer_q[i] + TMR_W'(1);
                        end
                    end
                    RPT_REPEAT: begin
                        if (timer_q[i] == RATE_LAST) begin
                            rpt_fire[i] = 1'b1;
                        end else begin
                            timer_d[i] = timer_q[i] + TMR_W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = RPT_IDLE;
                    end
                endcase
            end
        end
    end

    // Repeat FSM state and timers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < BTN_REPEAT_COUNT; i++) begin
                state_q[i] <= RPT_IDLE;
                timer_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < BTN_REPEAT_COUNT; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
        end
    end
`endif

    // Merge press edges with repeat strobes
    always_comb begin
        pulse_d = rise;
`ifdef BUTTON_AUTO_REPEAT_EN
        pulse_d[BTN_REPEAT_COUNT-1:0] = rise[BTN_REPEAT_COUNT-1:0] | rpt_fire;
`endif
    end

    // Strobe output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign btn_if.btn_level = level;
    assign btn_if.btn_pulse = pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_RATE=8). Follows BUTTON_AUTO_REPEAT_EN like the DUT.
`timescale 1ns/1ps
module tb_button_conditioner;
    import game_pkg::*;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 8;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    button_conditioner_if bif ();

    button_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .btn_if (bif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Level: toggles once the last DB synchronized samples (raw delayed by
    // two clocks) all disagree with it. Pulse: on the first high cycle, and
    // for repeating buttons at hold times RD, RD+RR, RD+2RR, ...
    logic [5:0] raw_hist [$];
    logic [5:0] eff_hist [$];
    logic [5:0] m_level = '0;
    logic [5:0] m_pulse = '0;
    logic [5:0] m_prev;
    logic [5:0] m_eff;
    int         m_held [6];
    bit         m_diff;
    bit         m_rep;

    always @(posedge clk) begin
        if (reset) begin
            raw_hist.delete();
            eff_hist.delete();
            m_level = '0;
            m_pulse = '0;
            for (int i = 0; i < 6; i++) m_held[i] = 0;
        end else begin
            raw_hist.push_back(bif.btn_raw);
            m_eff = (raw_hist.size() >= 3) ? raw_hist[raw_hist.size() - 3] : 6'b0;
            if (raw_hist.size() > 8) void'(raw_hist.pop_front());
            eff_hist.push_back(m_eff);
            if (eff_hist.size() > DB) void'(eff_hist.pop_front());
            m_prev = m_level;
            for (int i = 0; i < 6; i++) begin
                m_diff = 1'b1;
                for (int j = 0; j < eff_hist.size(); j++)
                    if (eff_hist[j][i] == m_level[i]) m_diff = 1'b0;
                if (eff_hist.size() == DB && m_diff) m_level[i] = ~m_level[i];
            end
            for (int i = 0; i < 6; i++) begin
                if (m_level[i] && !m_prev[i]) m_held[i] = 0;
                else if (m_level[i])          m_held[i] = m_held[i] + 1;
                m_rep = REPEAT_ON && (i < BTN_REPEAT_COUNT);
                m_pulse[i] = m_level[i] && (m_held[i] == 0 ||
                             (m_rep && m_held[i] >= RD && (m_held[i] - RD) % RR == 0));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_level", int'(bif.btn_level), int'(m_level));
            check("model_pulse", int'(bif.btn_pulse), int'(m_pulse));
        end
    end

    // ---------------- directed helpers ----------------
    int pulse_offs [$];

    // Press bit b for 'hold' cycles; report first level-high cycle (-1 if
    // none), pulse count, and pulse offsets relative to that cycle.
    task automatic run_press(input int b, input int hold, output int rise_at, output int npulse);
        logic [5:0] r;
        rise_at = -1;
        npulse  = 0;
        pulse_offs.delete();
        @(negedge clk);
        r = '0;
        r[b] = 1'b1;
        bif.btn_raw = r;
        for (int c = 1; c <= hold + 40; c++) begin
            @(negedge clk);
            if (bif.btn_level[b] && rise_at < 0) rise_at = c;
            if (bif.btn_pulse[b]) begin
                npulse++;
                pulse_offs.push_back(c - rise_at);
            end
            if (c == hold) bif.btn_raw = '0;
        end
    endtask

    // Cycles until btn_pulse[b] is seen, -1 if not within limit
    task automatic wait_pulse(input int b, input int limit, output int n);
        n = -1;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (bif.btn_pulse[b]) begin
                n = c;
                break;
            end
        end
    endtask

    typedef struct {
        int b;
        int hold;
        int exp_rise;
        int exp_rep;
        int exp_norep;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         rise_at, npulse, n;
        int         remain [6];
        logic [5:0] r;
        int         exp_offs [$];

        tbl[0] = '{4, 10, 6, 1, 1};
        tbl[1] = '{0,  3, -1, 0, 0};
        tbl[2] = '{2, 60, 6, 6, 1};
        tbl[3] = '{3, 60, 6, 6, 1};
        tbl[4] = '{5, 60, 6, 1, 1};
        tbl[5] = '{1, 25, 6, 2, 1};
        tbl[6] = '{0,  4, 6, 1, 1};
        tbl[7] = '{3, 29, 6, 3, 1};

        bif.btn_raw = '0;
        reset = 1'b1;
        @(negedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        check("reset_level", int'(bif.btn_level), 0);
        check("reset_pulse", int'(bif.btn_pulse), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Table-driven presses
        foreach (tbl[k]) begin
            run_press(tbl[k].b, tbl[k].hold, rise_at, npulse);
            check($sformatf("tbl%0d_rise", k), rise_at, tbl[k].exp_rise);
            check($sformatf("tbl%0d_npulse", k), npulse,
                  REPEAT_ON ? tbl[k].exp_rep : tbl[k].exp_norep);
        end

        // Repeat timing on aim_left
        run_press(2, 60, rise_at, npulse);
        if (REPEAT_ON) exp_offs = '{0, 20, 28, 36, 44, 52};
        else           exp_offs = '{0};
        check("rpt_count", pulse_offs.size(), exp_offs.size());
        for (int k = 0; k < exp_offs.size(); k++)
            check($sformatf("rpt_off%0d", k),
                  (k < pulse_offs.size()) ? pulse_offs[k] : -1, exp_offs[k]);

        // Simultaneous presses pulse together
        @(negedge clk);
        bif.btn_raw = 6'b000011;
        r = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bif.btn_pulse != 6'b0) begin
                r = bif.btn_pulse;
                break;
            end
        end
        check("simul_pulse", int'(r), 3);
        bif.btn_raw = '0;
        repeat (20) @(negedge clk);

        // Reset during a held press
        bif.btn_raw = 6'b000010;
        repeat (36) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_async_level", int'(bif.btn_level), 0);
        check("rst_async_pulse", int'(bif.btn_pulse), 0);
        repeat (3) @(negedge clk);
        check("rst_hold_level", int'(bif.btn_level), 0);
        reset = 1'b0;
        wait_pulse(1, 20, n);
        check("rst_first_pulse", n, 6);
        wait_pulse(1, 40, n);
        check("rst_next_pulse", n, REPEAT_ON ? RD : -1);
        bif.btn_raw = '0;
        repeat (20) @(negedge clk);

        // Randomized activity, with one reset in the middle
        for (int i = 0; i < 6; i++) remain[i] = $urandom_range(1, 8);
        r = '0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int i = 0; i < 6; i++) begin
                remain[i]--;
                if (remain[i] <= 0) begin
                    r[i] = ~r[i];
                    remain[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60)
                                                            : $urandom_range(1, 8);
                end
            end
            bif.btn_raw = r;
            if (c == 700) reset = 1'b1;
            if (c == 702) reset = 1'b0;
        end
        bif.btn_raw = '0;
        repeat (30) @(negedge clk);
        check("final_idle_level", int'(bif.btn_level), 0);

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL expose parameter DEBOUNCE_CYCLES, default 20000, meaning consecutive cycles a new input level must persist before acceptance.
REQ-002 The block SHALL expose parameter REPEAT_DELAY, default 4000000, meaning hold cycles from the first press pulse to the first repeat pulse.
REQ-003 The block SHALL expose parameter REPEAT_RATE, default 1000000, meaning cycles between successive repeat pulses.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 btn_raw  input  6  raw pad buttons, active-high; bit0 move_left, bit1 move_right, bit2 aim_left, bit3 aim_right, bit4 shoot, bit5 start_new_game.
REQ-007 btn_level  output  6  debounced held level per button, same bit order.
REQ-008 btn_pulse  output  6  one-cycle press/repeat strobe per button, same bit order; feeds the controls stage.

Function
REQ-009 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-010 Per bit, a counter SHALL increment each cycle the synchronized value differs from btn_level and clear to 0 on any cycle they match.
REQ-011 btn_level[i] SHALL toggle on the cycle its counter reaches DEBOUNCE_CYCLES, with the counter clearing that same cycle.
REQ-012 Raw-to-level latency SHALL be exactly DEBOUNCE_CYCLES+2 cycles for a clean edge; glitches shorter than DEBOUNCE_CYCLES cycles SHALL produce no level change.
REQ-013 btn_pulse[i] SHALL be high for exactly one cycle, namely the first cycle btn_level[i] is high; release SHALL produce no pulse.
REQ-014 Bits 0-3 SHALL each run a 3-state FSM: IDLE, DELAY, REPEAT.
REQ-015 IDLE->DELAY on the btn_level rise; DELAY->REPEAT after REPEAT_DELAY cycles, emitting a pulse; in REPEAT a pulse SHALL be emitted every REPEAT_RATE cycles.
REQ-016 Any state->IDLE in the cycle btn_level falls; the repeat timer SHALL clear and no pulse SHALL be emitted that cycle.
REQ-017 Bits 4-5 SHALL never repeat: exactly one pulse per debounced press regardless of hold time.
REQ-018 Bits SHALL be fully independent; simultaneous presses SHALL each be conditioned and pulsed without arbitration (multi-press rejection is downstream).
REQ-019 Counters SHALL saturate/clear and never wrap to produce a spurious toggle or pulse.

Reset
REQ-020 On reset: synchronizers, debounce counters, repeat timers 0; all FSMs IDLE; btn_level=6'b0; btn_pulse=6'b0.
REQ-021 Reset asserted mid-press SHALL abort immediately; a button held through reset release SHALL re-debounce and emit one fresh pulse.

Configuration
REQ-022 Macro BUTTON_AUTO_REPEAT_EN defined: REQ-014..REQ-016 active.
REQ-023 Macro BUTTON_AUTO_REPEAT_EN undefined: FSMs and repeat timers SHALL be omitted; all six bits behave per REQ-017; REPEAT_DELAY/REPEAT_RATE ignored.

Structure
REQ-024 Shared package game_pkg SHALL hold button index constants (BTN_MOVE_L..BTN_START), button count 6, and the repeat FSM state enum.
REQ-025 Sub-module btn_debounce (one bit: synchronizer + debounce counter + level) SHALL be instantiated six times; repeat FSMs live in the top.

Verification (bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8)
REQ-026 btn_raw[4] 0->1 held 10 cycles -> btn_level[4] rises 6 cycles after the edge; single btn_pulse[4]; none on release.
REQ-027 btn_raw[0] high for 3 cycles then low -> btn_level and btn_pulse stay 0.
REQ-028 btn_raw[2] held 60 cycles (repeat on) -> pulses at level-rise +0, +20, +28, +36, +44, +52; none after release.
REQ-029 btn_raw=6'b000011 simultaneously -> bits 0 and 1 pulse in the same cycle.
REQ-030 btn_raw[1] held, reset pulsed during REPEAT -> outputs 0 during reset; after release, one pulse 6 cycles later, then repeat restarts from DELAY.
REQ-031 BUTTON_AUTO_REPEAT_EN undefined, btn_raw[3] held 60 cycles -> exactly one btn_pulse[3].
